n64_vinput_demux: RTL and testbench



---
 rtl/n64_vinput_demux_pkg.sv | 24 ++
 rtl/n64_vinput_lockmon.sv | 68 ++++++
 rtl/n64_vinput_demux.sv | 124 ++++++++++++
 tb/tb_n64_vinput_demux.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/n64_vinput_demux_pkg.sv
// Shared constants for the N64 video input demultiplexer and its consumers.
// The PPU reads vdata_sync_o through the SYNC_* bit positions defined here.
package n64_vinput_demux_pkg;

   localparam logic [1:0] ST_HUNT = 2'd0;
   localparam logic [1:0] ST_R    = 2'd1;
   localparam logic [1:0] ST_G    = 2'd2;
   localparam logic [1:0] ST_B    = 2'd3;

   localparam int SYNC_VS    = 3;
   localparam int SYNC_CLAMP = 2;
   localparam int SYNC_HS    = 1;
   localparam int SYNC_CS    = 0;

   localparam logic [3:0] SYNC_IDLE = 4'hF;

   localparam int LOCK_THRESH_DEFAULT = 16;

   // True while the FSM is part-way through a pixel, so a sync here is premature.
   function automatic logic in_pixel(input logic [1:0] st);
      return (st != ST_HUNT);
   endfunction

endpackage

// File: rtl/n64_vinput_lockmon.sv
// Lock monitor: good-pixel run counter, locked flag and saturating alignment-error counter.
module n64_vinput_lockmon
   import n64_vinput_demux_pkg::*;
#(
   parameter int lock_thresh  = LOCK_THRESH_DEFAULT,
   parameter int errcnt_width = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    good_pix,
   input  logic                    err,
   input  logic                    gap,
   input  logic                    clr_err,
   output logic                    fire_ok,
   output logic                    locked,
   output logic [errcnt_width-1:0] err_cnt
);

   localparam logic [7:0]              THRESH  = 8'(lock_thresh);
   localparam logic [errcnt_width-1:0] ERR_ONE = errcnt_width'(1);

   logic [7:0]              good_cnt_r;
   logic [7:0]              good_cnt_nxt_s;
   logic [7:0]              good_inc_s;
   logic                    locked_r;
   logic [errcnt_width-1:0] err_cnt_r;

   // Next good-pixel count; a pixel may fire on the very cycle the threshold is reached.
   always_comb begin
      good_inc_s = (good_cnt_r >= THRESH) ? THRESH : (good_cnt_r + 8'd1);
      if (err || gap) begin
         good_cnt_nxt_s = 8'd0;
      end else if (good_pix) begin
         good_cnt_nxt_s = good_inc_s;
      end else begin
         good_cnt_nxt_s = good_cnt_r;
      end
      fire_ok = good_pix && (good_inc_s == THRESH);
   end

   // Good-pixel counter and locked flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         good_cnt_r <= 8'd0;
         locked_r   <= 1'b0;
      end else begin
         good_cnt_r <= good_cnt_nxt_s;
         locked_r   <= (good_cnt_nxt_s == THRESH);
      end
   end

   // Saturating alignment-error counter; clear has priority over a coincident error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_r <= '0;
      end else if (clr_err) begin
         err_cnt_r <= '0;
      end else if (err && !(&err_cnt_r)) begin
         err_cnt_r <= err_cnt_r + ERR_ONE;
      end else begin
         err_cnt_r <= err_cnt_r;
      end
   end

   assign locked  = locked_r;
   assign err_cnt = err_cnt_r;

endmodule

// File: rtl/n64_vinput_demux.sv
// N64 4-phase video demultiplexer: sync/R/G/B phases into one registered RGB word
// plus sync nibble, with phase lock tracking and alignment-error counting.
module n64_vinput_demux
   import n64_vinput_demux_pkg::*;
#(
   parameter int color_width_i = 7,
   parameter int lock_thresh   = LOCK_THRESH_DEFAULT,
   parameter int errcnt_width  = 8
) (
   input  logic                       N64_CLK_i,
   input  logic                       N64_nVRST_i,
   input  logic                       nVDSYNC_i,
   input  logic [color_width_i-1:0]   VD_i,
   output logic                       vdata_valid_o,
   output logic [3:0]                 vdata_sync_o,
   output logic [3*color_width_i-1:0] vdata_rgb_o,
   output logic                       locked_o,
   output logic [errcnt_width-1:0]    align_err_cnt_o,
   input  logic                       clr_err_i
);

   logic [1:0]                 state_r;
   logic [1:0]                 state_nxt_s;
   logic                       after_b_r;
   logic [3:0]                 sync_sh_r;
   logic [color_width_i-1:0]   r_r;
   logic [color_width_i-1:0]   g_r;
   logic                       valid_r;
   logic [3:0]                 sync_out_r;
   logic [3*color_width_i-1:0] rgb_r;
   logic                       good_pix_s;
   logic                       err_s;
   logic                       gap_s;
   logic                       fire_ok_s;

   // Phase sequencing; a sync restarts the pixel from any state.
   always_comb begin
      state_nxt_s = state_r;
      good_pix_s  = 1'b0;
      err_s       = 1'b0;
      gap_s       = 1'b0;
      if (!nVDSYNC_i) begin
         state_nxt_s = ST_R;
         err_s       = in_pixel(state_r);
      end else begin
         case (state_r)
            ST_HUNT: begin
               state_nxt_s = ST_HUNT;
               gap_s       = after_b_r;
            end
            ST_R:    state_nxt_s = ST_G;
            ST_G:    state_nxt_s = ST_B;
            ST_B: begin
               state_nxt_s = ST_HUNT;
               good_pix_s  = 1'b1;
            end
            default: state_nxt_s = ST_HUNT;
         endcase
      end
   end

   // FSM state and the "previous cycle captured B" marker used for gap detection.
   always_ff @(posedge N64_CLK_i or negedge N64_nVRST_i) begin
      if (!N64_nVRST_i) begin
         state_r   <= ST_HUNT;
         after_b_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         after_b_r <= good_pix_s;
      end
   end

   // Shadow capture of sync and colour phases, independent of lock.
   always_ff @(posedge N64_CLK_i or negedge N64_nVRST_i) begin
      if (!N64_nVRST_i) begin
         sync_sh_r <= SYNC_IDLE;
         r_r       <= '0;
         g_r       <= '0;
      end else if (!nVDSYNC_i) begin
         sync_sh_r <= {VD_i[SYNC_VS], VD_i[SYNC_CLAMP], VD_i[SYNC_HS], VD_i[SYNC_CS]};
      end else if (state_r == ST_R) begin
         r_r <= VD_i;
      end else if (state_r == ST_G) begin
         g_r <= VD_i;
      end else begin
         sync_sh_r <= sync_sh_r;
      end
   end

   n64_vinput_lockmon #(
      .lock_thresh  (lock_thresh),
      .errcnt_width (errcnt_width)
   ) u_lockmon (
      .clk      (N64_CLK_i),
      .rst_n    (N64_nVRST_i),
      .good_pix (good_pix_s),
      .err      (err_s),
      .gap      (gap_s),
      .clr_err  (clr_err_i),
      .fire_ok  (fire_ok_s),
      .locked   (locked_o),
      .err_cnt  (align_err_cnt_o)
   );

   // Output word: B comes straight off the bus on its capture edge; outputs hold otherwise.
   always_ff @(posedge N64_CLK_i or negedge N64_nVRST_i) begin
      if (!N64_nVRST_i) begin
         valid_r    <= 1'b0;
         sync_out_r <= SYNC_IDLE;
         rgb_r      <= '0;
      end else if (fire_ok_s) begin
         valid_r    <= 1'b1;
         sync_out_r <= sync_sh_r;
         rgb_r      <= {r_r, g_r, VD_i};
      end else begin
         valid_r    <= 1'b0;
      end
   end

   assign vdata_valid_o = valid_r;
   assign vdata_sync_o  = sync_out_r;
   assign vdata_rgb_o   = rgb_r;

endmodule

// File: tb/tb_n64_vinput_demux.sv
// Bench for n64_vinput_demux: a history-window model of the sync/R/G/B stream
// checked every cycle, plus literal checks on the directed scenarios.
module tb_n64_vinput_demux;
   import n64_vinput_demux_pkg::*;

   localparam int THR = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        nvdsync = 1'b1;
   logic [6:0]  vd_bus = 7'd0;
   logic        clr_err = 1'b0;
   logic        valid;
   logic [3:0]  sync_o;
   logic [20:0] rgb;
   logic        locked;
   logic [7:0]  err_cnt;

   int tests = 0;
   int fails = 0;

   // Model state: h[k]/v[k] are nVDSYNC/VD sampled k edges ago (k=0 is the latest edge).
   logic        h [0:4];
   logic [6:0]  v [0:4];
   int          m_cnt = 0;
   logic [7:0]  m_err = 8'd0;
   logic        exp_valid = 1'b0;
   logic [3:0]  exp_sync = 4'hF;
   logic [20:0] exp_rgb = 21'd0;
   logic        exp_locked = 1'b0;

   n64_vinput_demux dut (
      .N64_CLK_i       (clk),
      .N64_nVRST_i     (rst_n),
      .nVDSYNC_i       (nvdsync),
      .VD_i            (vd_bus),
      .vdata_valid_o   (valid),
      .vdata_sync_o    (sync_o),
      .vdata_rgb_o     (rgb),
      .locked_o        (locked),
      .align_err_cnt_o (err_cnt),
      .clr_err_i       (clr_err)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < 5; i++) begin
         h[i] = 1'b1;
         v[i] = 7'd0;
      end
      m_cnt = 0; m_err = 8'd0;
      exp_valid = 1'b0; exp_sync = 4'hF; exp_rgb = 21'd0; exp_locked = 1'b0;
   endtask

   // A pixel ends on the edge whose window reads sync,1,1,1; errors and gaps are window patterns too.
   task automatic model_step();
      logic good, err, gap, fire;
      for (int i = 4; i > 0; i--) begin
         h[i] = h[i-1];
         v[i] = v[i-1];
      end
      h[0] = nvdsync;
      v[0] = vd_bus;
      good = !h[3] && h[2] && h[1] && h[0];
      err  = !h[0] && (!h[1] || (!h[2] && h[1]) || (!h[3] && h[2] && h[1]));
      gap  = h[0] && !h[4] && h[3] && h[2] && h[1];
      fire = 1'b0;
      if (err || gap) begin
         m_cnt = 0;
      end else if (good) begin
         if (m_cnt < THR) m_cnt++;
         fire = (m_cnt == THR);
      end
      exp_locked = (m_cnt == THR);
      if (clr_err) m_err = 8'd0;
      else if (err && m_err != 8'hFF) m_err++;
      exp_valid = fire;
      if (fire) begin
         exp_sync = v[3][3:0];
         exp_rgb  = {v[2], v[1], v[0]};
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         tests++;
         if ({valid, sync_o, rgb, locked, err_cnt} !==
             {exp_valid, exp_sync, exp_rgb, exp_locked, m_err}) begin
            fails++;
            $display("FAIL model t=%0t: got valid=%0b sync=%h rgb=%h lock=%0b err=%0d, want valid=%0b sync=%h rgb=%h lock=%0b err=%0d",
                     $time, valid, sync_o, rgb, locked, err_cnt,
                     exp_valid, exp_sync, exp_rgb, exp_locked, m_err);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %h, want %h", name, act, want);
      end
   endtask

   task automatic cyc(input logic nvs, input logic [6:0] vd, input logic clr);
      nvdsync = nvs;
      vd_bus  = vd;
      clr_err = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic send_pix(input logic [3:0] s, input logic [6:0] r, input logic [6:0] g,
                           input logic [6:0] b);
      cyc(1'b0, {3'b000, s}, 1'b0);
      cyc(1'b1, r, 1'b0);
      cyc(1'b1, g, 1'b0);
      cyc(1'b1, b, 1'b0);
   endtask

   initial begin
      logic [7:0] e0;
      int         sel;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", {31'd0, valid}, 32'd0);
      chk("reset_sync", {28'd0, sync_o}, 32'h0000000F);
      chk("reset_rgb", {11'd0, rgb}, 32'd0);
      chk("reset_lock", {31'd0, locked}, 32'd0);
      rst_n = 1'b1;
      cyc(1'b1, 7'd0, 1'b0);

      // Clean stream: lock and first strobe on pixel 16.
      for (int p = 1; p <= 20; p++) begin
         send_pix(4'hF, 7'h11, 7'h22, 7'h33);
         if (p == 15) begin
            chk("p15_no_strobe", {31'd0, valid}, 32'd0);
            chk("p15_unlocked", {31'd0, locked}, 32'd0);
         end
         if (p == 16) begin
            chk("p16_strobe", {31'd0, valid}, 32'd1);
            chk("p16_rgb", {11'd0, rgb}, 32'h00045133);
            chk("p16_sync", {28'd0, sync_o}, 32'h0000000F);
            chk("p16_locked", {31'd0, locked}, 32'd1);
            chk("p16_errcnt", {24'd0, err_cnt}, 32'd0);
         end
      end

      // Premature sync in the G phase.
      cyc(1'b0, 7'h0F, 1'b0);
      cyc(1'b1, 7'h01, 1'b0);
      cyc(1'b0, 7'h0F, 1'b0);
      chk("err_unlock", {31'd0, locked}, 32'd0);
      chk("err_count1", {24'd0, err_cnt}, 32'd1);
      cyc(1'b1, 7'h01, 1'b0);
      cyc(1'b1, 7'h02, 1'b0);
      cyc(1'b1, 7'h03, 1'b0);
      chk("err_no_strobe", {31'd0, valid}, 32'd0);
      for (int p = 0; p < 20; p++) send_pix(4'hF, 7'h11, 7'h22, 7'h33);
      chk("relock", {31'd0, locked}, 32'd1);

      // Distinct sync word shows up only with its own strobe.
      cyc(1'b0, 7'h05, 1'b0);
      cyc(1'b1, 7'h7F, 1'b0);
      cyc(1'b1, 7'h40, 1'b0);
      chk("sync_hold", {28'd0, sync_o}, 32'h0000000F);
      chk("rgb_hold", {11'd0, rgb}, 32'h00045133);
      cyc(1'b1, 7'h01, 1'b0);
      chk("sync_0101", {28'd0, sync_o}, 32'h00000005);
      chk("sync_strobe", {31'd0, valid}, 32'd1);

      // Idle gap after B: unlock without an error.
      e0 = err_cnt;
      cyc(1'b1, 7'h00, 1'b0);
      chk("gap_unlock", {31'd0, locked}, 32'd0);
      chk("gap_no_err", {24'd0, err_cnt}, {24'd0, e0});
      for (int p = 0; p < THR; p++) send_pix(4'hF, 7'h11, 7'h22, 7'h33);
      chk("gap_relock", {31'd0, locked}, 32'd1);

      // Error counter saturation, then clear coincident with an error.
      for (int i = 0; i < 300; i++) cyc(1'b0, 7'($urandom_range(0, 127)), 1'b0);
      chk("err_saturate", {24'd0, err_cnt}, 32'h000000FF);
      cyc(1'b0, 7'h0F, 1'b1);
      chk("clr_wins", {24'd0, err_cnt}, 32'd0);
      cyc(1'b1, 7'h00, 1'b0);
      cyc(1'b1, 7'h00, 1'b0);
      cyc(1'b1, 7'h00, 1'b0);

      // Asynchronous reset during the R phase of a locked stream.
      for (int p = 0; p < THR + 2; p++) send_pix(4'hF, 7'h2A, 7'h15, 7'h6C);
      cyc(1'b0, 7'h0F, 1'b0);
      nvdsync = 1'b1;
      vd_bus  = 7'h2A;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_lock", {31'd0, locked}, 32'd0);
      chk("arst_rgb", {11'd0, rgb}, 32'd0);
      chk("arst_sync", {28'd0, sync_o}, 32'h0000000F);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int p = 1; p <= THR; p++) begin
         send_pix(4'hF, 7'h10, 7'h20, 7'h30);
         if (p == THR - 1) chk("post_rst_nostrobe", {31'd0, valid}, 32'd0);
      end
      chk("post_rst_strobe", {31'd0, valid}, 32'd1);

      // Randomised stream: clean pixels, truncated pixels, idle cycles, occasional clears.
      for (int it = 0; it < 1500; it++) begin
         sel = $urandom_range(0, 99);
         if (sel < 75) begin
            cyc(1'b0, 7'($urandom_range(0, 127)), ($urandom_range(0, 49) == 0));
            for (int k = 0; k < 3; k++)
               cyc(1'b1, 7'($urandom_range(0, 127)), ($urandom_range(0, 49) == 0));
         end else if (sel < 85) begin
            cyc(1'b1, 7'($urandom_range(0, 127)), 1'b0);
         end else begin
            cyc(1'b0, 7'($urandom_range(0, 127)), 1'b0);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++)
               cyc(1'b1, 7'($urandom_range(0, 127)), ($urandom_range(0, 49) == 0));
         end
      end

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
